// File: rtl/dct_pkg.sv
// Constants, FSM encoding and saturation helper shared by the forward and inverse 4-point DCT stages.
package dct_pkg;

  localparam int C64 = 64;
  localparam int C83 = 83;
  localparam int C36 = 36;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    BFLY    = 2'd1,
    MAC     = 2'd2,
    OUT     = 2'd3
  } dct_state_e;

  // Clamp a sign-extended value to the signed range of a dw-bit result.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int unsigned dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) sat = hi;
    else if (v < lo) sat = lo;
    else sat = v;
  endfunction

endpackage

// File: rtl/fdct4_butterfly.sv
// Combinational even/odd butterfly of the 4-point forward DCT; results are one bit wider than the samples.
module fdct4_butterfly #(
  parameter int DW = 25
) (
  input  logic signed [DW-1:0] x0,
  input  logic signed [DW-1:0] x1,
  input  logic signed [DW-1:0] x2,
  input  logic signed [DW-1:0] x3,
  output logic signed [DW:0]   e0,
  output logic signed [DW:0]   e1,
  output logic signed [DW:0]   o0,
  output logic signed [DW:0]   o1
);

  logic signed [DW:0] w0, w1, w2, w3;

  assign w0 = {x0[DW-1], x0};
  assign w1 = {x1[DW-1], x1};
  assign w2 = {x2[DW-1], x2};
  assign w3 = {x3[DW-1], x3};

  assign e0 = w0 + w3;
  assign e1 = w1 + w2;
  assign o0 = w0 - w3;
  assign o1 = w1 - w2;

endmodule

// File: rtl/fdct4_serial_fwd.sv
// Serial-in, parallel-out 4-point forward integer DCT: collect a row, butterfly, MAC, round/shift/saturate.
module fdct4_serial_fwd
  import dct_pkg::*;
#(
  parameter int DW    = 25,
  parameter int SHIFT = 1,
  parameter int IW    = DW + 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_first,
  input  logic signed [DW-1:0] s_in,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] coef_0,
  output logic signed [DW-1:0] coef_1,
  output logic signed [DW-1:0] coef_2,
  output logic signed [DW-1:0] coef_3,
  output logic                 sync_err,
  output dct_state_e           dbg_state
);

  localparam logic signed [IW-1:0] K64 = IW'(C64);
  localparam logic signed [IW-1:0] K83 = IW'(C83);
  localparam logic signed [IW-1:0] K36 = IW'(C36);
  localparam logic signed [IW-1:0] RND = IW'(1 << (SHIFT - 1));

  dct_state_e state, state_nx;
  logic [1:0] cnt;
  logic [1:0] idx;
  logic       accept;
  logic signed [DW-1:0] x_q [4];
  logic signed [DW:0]   e0_w, e1_w, o0_w, o1_w;
  logic signed [DW:0]   e0_q, e1_q, o0_q, o1_q;
  logic signed [IW-1:0] ee0, ee1, oo0, oo1;
  logic signed [IW-1:0] y0, y1, y2, y3;

  // Handshakes: a beat transfers on a rising edge where valid and ready are both high; in_ready
  // depends only on state, and the coefficients stay frozen while out_valid waits for out_ready.
  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == OUT);
  assign accept    = in_valid & in_ready;
  assign idx       = in_first ? 2'd0 : cnt;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= COLLECT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      COLLECT: if (accept && idx == 2'd3) state_nx = BFLY;
      BFLY:    state_nx = MAC;
      MAC:     state_nx = OUT;
      OUT:     if (out_ready) state_nx = COLLECT;
      default: state_nx = COLLECT;
    endcase
  end

  // in_first always restarts the row at x0; a restart over a partial row is flagged for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= 2'd0;
      sync_err <= 1'b0;
      for (int i = 0; i < 4; i++) x_q[i] <= '0;
    end else begin
      sync_err <= accept && in_first && (cnt != 2'd0);
      if (accept) begin
        x_q[idx] <= s_in;
        cnt      <= (idx == 2'd3) ? 2'd0 : idx + 2'd1;
      end
    end
  end

  fdct4_butterfly #(.DW(DW)) u_bfly (
    .x0(x_q[0]), .x1(x_q[1]), .x2(x_q[2]), .x3(x_q[3]),
    .e0(e0_w),   .e1(e1_w),   .o0(o0_w),   .o1(o1_w)
  );

  assign ee0 = {{(IW-DW-1){e0_q[DW]}}, e0_q};
  assign ee1 = {{(IW-DW-1){e1_q[DW]}}, e1_q};
  assign oo0 = {{(IW-DW-1){o0_q[DW]}}, o0_q};
  assign oo1 = {{(IW-DW-1){o1_q[DW]}}, o1_q};

  assign y0 = K64 * ee0 + K64 * ee1;
  assign y1 = K83 * oo0 + K36 * oo1;
  assign y2 = K64 * ee0 - K64 * ee1;
  assign y3 = K36 * oo0 - K83 * oo1;

  function automatic logic signed [DW-1:0] round_sat(input logic signed [IW-1:0] y);
    logic signed [IW-1:0] r;
    logic signed [63:0]   w;
    r = (y + RND) >>> SHIFT;
    w = {{(64-IW){r[IW-1]}}, r};
    w = sat(w, DW);
    return w[DW-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e0_q   <= '0;
      e1_q   <= '0;
      o0_q   <= '0;
      o1_q   <= '0;
      coef_0 <= '0;
      coef_1 <= '0;
      coef_2 <= '0;
      coef_3 <= '0;
    end else begin
      if (state == BFLY) begin
        e0_q <= e0_w;
        e1_q <= e1_w;
        o0_q <= o0_w;
        o1_q <= o1_w;
      end
      if (state == MAC) begin
        coef_0 <= round_sat(y0);
        coef_1 <= round_sat(y1);
        coef_2 <= round_sat(y2);
        coef_3 <= round_sat(y3);
      end
    end
  end

endmodule

// File: tb/tb_fdct4_serial_fwd.sv
// Bench for fdct4_serial_fwd: row pass (SHIFT=1) and column pass (SHIFT=8) instances on shared stimulus.
module tb_fdct4_serial_fwd;
  localparam int DW = 25;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_first = 1'b0;
  logic signed [DW-1:0] s_in = '0;
  logic out_ready = 1'b1;

  logic in_ready, out_valid, sync_err;
  logic in_ready8, out_valid8, sync_err8;
  logic signed [DW-1:0] c1_0, c1_1, c1_2, c1_3;
  logic signed [DW-1:0] c8_0, c8_1, c8_2, c8_3;
  dct_pkg::dct_state_e dbg1, dbg8;
  logic [4*DW-1:0] got1, got8;

  logic [4*DW-1:0] exp_q[$];
  logic [4*DW-1:0] exp8_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_out_cyc = 0;

  assign got1 = {c1_3, c1_2, c1_1, c1_0};
  assign got8 = {c8_3, c8_2, c8_1, c8_0};

  fdct4_serial_fwd #(.DW(DW), .SHIFT(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_first(in_first), .s_in(s_in),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .coef_0(c1_0), .coef_1(c1_1), .coef_2(c1_2), .coef_3(c1_3),
    .sync_err(sync_err), .dbg_state(dbg1)
  );

  fdct4_serial_fwd #(.DW(DW), .SHIFT(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_first(in_first), .s_in(s_in),
    .in_ready(in_ready8), .out_valid(out_valid8), .out_ready(out_ready),
    .coef_0(c8_0), .coef_1(c8_1), .coef_2(c8_2), .coef_3(c8_3),
    .sync_err(sync_err8), .dbg_state(dbg8)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: DCT equations on plain integers, rounding shift, clamp to DW bits.
  function automatic logic [4*DW-1:0] model(input longint a, input longint b, input longint c,
                                            input longint d, input int sh);
    longint e0, e1, o0, o1, hi, lo, r;
    longint y[4];
    logic [4*DW-1:0] res;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -hi - 1;
    e0 = a + d; e1 = b + c; o0 = a - d; o1 = b - c;
    y[0] = 64 * e0 + 64 * e1;
    y[1] = 83 * o0 + 36 * o1;
    y[2] = 64 * e0 - 64 * e1;
    y[3] = 36 * o0 - 83 * o1;
    res = '0;
    for (int k = 0; k < 4; k++) begin
      r = (y[k] + (longint'(1) << (sh - 1))) >>> sh;
      if (r > hi) r = hi;
      if (r < lo) r = lo;
      res[k*DW +: DW] = r[DW-1:0];
    end
    return res;
  endfunction

  // driver tasks (called and returning at a falling edge)
  task automatic send(input logic [DW-1:0] v, input logic f);
    int n;
    n = 0;
    in_valid = 1'b1; in_first = f; s_in = v;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready=0 for %0d cycles, required 1", n);
    end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0;
  endtask

  task automatic push_row(input int a, input int b, input int c, input int d, input logic f);
    exp_q.push_back(model(a, b, c, d, 1));
    exp8_q.push_back(model(a, b, c, d, 8));
    send(a[DW-1:0], f); send(b[DW-1:0], 1'b0); send(c[DW-1:0], 1'b0); send(d[DW-1:0], 1'b0);
  endtask

  task automatic rand_row(input logic f);
    logic signed [DW-1:0] rv[4];
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 1) == 1) rv[k] = DW'($urandom);
      else rv[k] = DW'(int'($urandom_range(0, 400)) - 200);
    end
    push_row(int'(rv[0]), int'(rv[1]), int'(rv[2]), int'(rv[3]), f);
  endtask

  // scoreboard: wait for a result, compare both instances, complete the handshake
  task automatic check_out(input string name);
    int n;
    logic [4*DW-1:0] e1, e8;
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    n_checks++;
    if (!out_valid) $display("FAIL %s_timeout: out_valid=0 after %0d cycles, required 1", name, n);
    else n_pass++;
    last_out_cyc = cyc;
    n_checks++;
    if (exp_q.size() == 0 || exp8_q.size() == 0) begin
      $display("FAIL %s_queue: result present with %0d expected rows, required >=1", name, exp_q.size());
    end else begin
      n_pass++;
      e1 = exp_q.pop_front();
      e8 = exp8_q.pop_front();
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (got1[k*DW +: DW] !== e1[k*DW +: DW])
          $display("FAIL %s coef_%0d: got %0d required %0d", name, k,
                   $signed(got1[k*DW +: DW]), $signed(e1[k*DW +: DW]));
        else n_pass++;
        n_checks++;
        if (got8[k*DW +: DW] !== e8[k*DW +: DW])
          $display("FAIL %s shift8 coef_%0d: got %0d required %0d", name, k,
                   $signed(got8[k*DW +: DW]), $signed(e8[k*DW +: DW]));
        else n_pass++;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic check_idle_after_reset(input string name);
    n_checks++;
    if (out_valid !== 1'b0 || out_valid8 !== 1'b0)
      $display("FAIL %s out_valid: got %b/%b required 0/0", name, out_valid, out_valid8);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1 || in_ready8 !== 1'b1)
      $display("FAIL %s in_ready: got %b/%b required 1/1", name, in_ready, in_ready8);
    else n_pass++;
    n_checks++;
    if (got1 !== '0 || got8 !== '0) $display("FAIL %s coefs: got %h/%h required 0", name, got1, got8);
    else n_pass++;
    n_checks++;
    if (sync_err !== 1'b0) $display("FAIL %s sync_err: got %b required 0", name, sync_err);
    else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #12;
    check_idle_after_reset("reset");
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic;
    logic [4*DW-1:0] want;
    want = {DW'(0), DW'(0), DW'(0), DW'(128)};
    push_row(1, 1, 1, 1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL lat_bfly: out_valid=%b in_ready=%b required 0/0", out_valid, in_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL lat_mac: out_valid=%b required 0", out_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL lat_out: out_valid=%b required 1", out_valid);
    else n_pass++;
    n_checks++;
    if (got1 !== want) $display("FAIL basic_const: got %h required %h", got1, want);
    else n_pass++;
    check_out("basic");
  endtask

  task automatic test_patterns;
    push_row(1, 0, 0, -1, 1'b1);
    check_out("pat_odd0");
    push_row(0, 1, -1, 0, 1'b0);
    check_out("pat_odd1");
    for (int i = 0; i < 12; i++) begin
      rand_row(1'($urandom_range(0, 1)));
      check_out("random");
    end
  endtask

  task automatic test_saturation;
    push_row(16777215, 16777215, 16777215, 16777215, 1'b1);
    check_out("sat_pos");
    push_row(-16777216, -16777216, -16777216, -16777216, 1'b0);
    check_out("sat_neg");
  endtask

  task automatic test_backpressure;
    logic [4*DW-1:0] snap;
    int n;
    out_ready = 1'b0;
    rand_row(1'b1);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    snap = got1;
    in_valid = 1'b1; in_first = 1'b1; s_in = DW'($urandom);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (got1 !== snap) $display("FAIL bp_stable: got %h required %h", got1, snap);
      else n_pass++;
      n_checks++;
      if (out_valid !== 1'b1) $display("FAIL bp_valid: got %b required 1", out_valid);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b required 0", in_ready);
      else n_pass++;
      @(negedge clk);
    end
    in_valid = 1'b0; in_first = 1'b0;
    check_out("bp");
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int prev;
    prev = -1;
    fork
      begin
        for (int i = 0; i < 4; i++) rand_row(1'($urandom_range(0, 1)));
      end
      begin
        for (int i = 0; i < 4; i++) begin
          check_out("b2b");
          if (prev >= 0) begin
            n_checks++;
            if (last_out_cyc - prev != 7)
              $display("FAIL b2b_period: got %0d cycles required 7", last_out_cyc - prev);
            else n_pass++;
          end
          prev = last_out_cyc;
        end
      end
    join
  endtask

  task automatic test_resync;
    send(DW'(11), 1'b1);
    send(DW'(22), 1'b0);
    send(DW'(33), 1'b1);
    n_checks++;
    if (sync_err !== 1'b1 || sync_err8 !== 1'b1)
      $display("FAIL resync_pulse: got %b/%b required 1/1", sync_err, sync_err8);
    else n_pass++;
    exp_q.push_back(model(33, 44, 55, 66, 1));
    exp8_q.push_back(model(33, 44, 55, 66, 8));
    send(DW'(44), 1'b0);
    n_checks++;
    if (sync_err !== 1'b0) $display("FAIL resync_single: got %b required 0", sync_err);
    else n_pass++;
    send(DW'(55), 1'b0);
    send(DW'(66), 1'b0);
    check_out("resync");
  endtask

  task automatic test_reset_mid;
    int n;
    push_row(5, 6, 7, 8, 1'b1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1 check_idle_after_reset("rst_mac");
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete(); exp8_q.delete();
    out_ready = 1'b0;
    push_row(9, -3, 4, 2, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    #1 reset = 1'b0;
    #1 check_idle_after_reset("rst_out");
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete(); exp8_q.delete();
    out_ready = 1'b1;
    send(DW'(7), 1'b0);
    send(DW'(8), 1'b0);
    #1 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    push_row(1, 1, 1, 1, 1'b0);
    check_out("post_reset");
  endtask

  task automatic test_shift8;
    int n;
    push_row(128, 128, 128, 128, 1'b1);
    n = 0;
    while (!out_valid8 && n < 20) begin @(negedge clk); n++; end
    n_checks++;
    if (c8_0 !== DW'(128)) $display("FAIL shift8_c0: got %0d required 128", c8_0);
    else n_pass++;
    n_checks++;
    if (c1_0 !== DW'(16384)) $display("FAIL shift1_c0: got %0d required 16384", c1_0);
    else n_pass++;
    check_out("shift8");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_resync();
    test_reset_mid();
    test_shift8();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
